alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_rr_arbiter.sv | 35 +++
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU arbiter slice.
//   - OP_* opcodes understood by the shared ALU (1..9 valid).
//   - FLAG_* bit positions in the 5-bit flag word
//     {invalid_op, parity, zero, borrow, carry_out}.
//   - arb_state_t: arbiter FSM state encoding.
//   - sat_inc8: saturating 8-bit increment for grant statistics.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;

  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_BORROW  = 1;
  localparam int FLAG_ZERO    = 2;
  localparam int FLAG_PARITY  = 3;
  localparam int FLAG_INVALID = 4;
  localparam int FLAG_W       = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } arb_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of every non-clock signal of alu_arbiter.
//   master modport: requester / ALU side (drives requests, response
//                   ready, and the ALU result back).
//   slave modport : arbiter side.
// Handshake rule for both req and rsp channels: a transfer happens on a
// rising edge where valid and ready are both 1; valid may not depend on
// ready, and the sender holds its payload stable while valid is high and
// ready is low.
interface alu_arbiter_if #(parameter int BUS_WIDTH = 8);
  import alu_pkg::*;

  logic                 req0_valid, req1_valid;
  logic                 req0_ready, req1_ready;
  logic [3:0]           req0_opcode, req1_opcode;
  logic [BUS_WIDTH-1:0] req0_a, req1_a;
  logic [BUS_WIDTH-1:0] req0_b, req1_b;
  logic                 req0_carry_in, req1_carry_in;
  logic                 rsp0_valid, rsp1_valid;
  logic                 rsp0_ready, rsp1_ready;
  logic [BUS_WIDTH-1:0] rsp0_y, rsp1_y;
  logic [FLAG_W-1:0]    rsp0_flags, rsp1_flags;
  logic [3:0]           alu_opcode;
  logic [BUS_WIDTH-1:0] alu_a, alu_b;
  logic                 alu_carry_in;
  logic [BUS_WIDTH-1:0] alu_y;
  logic [FLAG_W-1:0]    alu_flags;
  logic                 busy;
  logic [7:0]           grant_cnt0, grant_cnt1;

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b, req0_carry_in,
    output req1_valid, req1_opcode, req1_a, req1_b, req1_carry_in,
    output rsp0_ready, rsp1_ready, alu_y, alu_flags,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp0_y, rsp1_y, rsp0_flags, rsp1_flags,
    input  alu_opcode, alu_a, alu_b, alu_carry_in,
    input  busy, grant_cnt0, grant_cnt1
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b, req0_carry_in,
    input  req1_valid, req1_opcode, req1_a, req1_b, req1_carry_in,
    input  rsp0_ready, rsp1_ready, alu_y, alu_flags,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp0_y, rsp1_y, rsp0_flags, rsp1_flags,
    output alu_opcode, alu_a, alu_b, alu_carry_in,
    output busy, grant_cnt0, grant_cnt1
  );

endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: 2-way round-robin tie breaker.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : eligible requesters
//   advance    : grant is being taken this cycle (pointer may move)
//   grant[1:0] : one-hot grant (combinational)
// The last-grant pointer resets to 1 so requester 0 wins the first tie.
module alu_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   reqN_*              : operation request channel (valid/ready)
//   rspN_*              : one-deep response buffer per requester
//   alu_*               : operand drive to / result from the shared ALU
//   busy                : high while the FSM is in EXEC
//   grant_cntN          : saturating grant counters
// Optional feature: define ALU_ARB_STATS_EN to enable grant_cntN counting;
// otherwise the counters are tied to 0.
// Flow: IDLE grants one eligible requester and latches its operands;
// EXEC lasts one cycle, at whose end the ALU result is captured into the
// owner's response buffer. A requester holding an unconsumed response is
// not eligible, so at most one grant occurs every two cycles.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [3:0]           req0_opcode,
  input  logic [BUS_WIDTH-1:0] req0_a,
  input  logic [BUS_WIDTH-1:0] req0_b,
  input  logic                 req0_carry_in,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [3:0]           req1_opcode,
  input  logic [BUS_WIDTH-1:0] req1_a,
  input  logic [BUS_WIDTH-1:0] req1_b,
  input  logic                 req1_carry_in,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [BUS_WIDTH-1:0] rsp0_y,
  output logic [FLAG_W-1:0]    rsp0_flags,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [BUS_WIDTH-1:0] rsp1_y,
  output logic [FLAG_W-1:0]    rsp1_flags,
  output logic [3:0]           alu_opcode,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  input  logic [BUS_WIDTH-1:0] alu_y,
  input  logic [FLAG_W-1:0]    alu_flags,
  output logic                 busy,
  output logic [7:0]           grant_cnt0,
  output logic [7:0]           grant_cnt1
);

  arb_state_t state;
  logic       owner;      // requester whose operation is in EXEC
  logic       idle;
  logic [1:0] eligible;
  logic [1:0] grant;

  assign idle = (state == ST_IDLE);

  // Registered rsp_valid only: a response consumed this cycle still blocks.
  assign eligible = {req1_valid & ~rsp1_valid, req0_valid & ~rsp0_valid};

  alu_rr_arbiter u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (eligible),
    .advance (idle),
    .grant   (grant)
  );

  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      owner        <= 1'b0;
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_carry_in <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_y       <= '0;
      rsp0_flags   <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_y       <= '0;
      rsp1_flags   <= '0;
    end else begin
      if (rsp0_valid && rsp0_ready) rsp0_valid <= 1'b0;
      if (rsp1_valid && rsp1_ready) rsp1_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            state        <= ST_EXEC;
            busy         <= 1'b1;
            owner        <= grant[1];
            alu_opcode   <= grant[1] ? req1_opcode   : req0_opcode;
            alu_a        <= grant[1] ? req1_a        : req0_a;
            alu_b        <= grant[1] ? req1_b        : req0_b;
            alu_carry_in <= grant[1] ? req1_carry_in : req0_carry_in;
          end
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          // The owner's buffer was empty at grant time, so no clash with
          // the consume clear above.
          if (owner) begin
            rsp1_valid <= 1'b1;
            rsp1_y     <= alu_y;
            rsp1_flags <= alu_flags;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_y     <= alu_y;
            rsp0_flags <= alu_flags;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else begin
      if (req0_ready) grant_cnt0 <= sat_inc8(grant_cnt0);
      if (req1_ready) grant_cnt1 <= sat_inc8(grant_cnt1);
    end
  end
`else
  assign grant_cnt0 = 8'd0;
  assign grant_cnt1 = 8'd0;
`endif

endmodule
